// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU retirement-trace capture block.
package cpu_trace_pkg;

  localparam int TRACE_ENTRY_W = 98;
  localparam int DROP_CNT_W    = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] f;
    logic [31:0] mem;
    logic        zf;
    logic        of;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Synchronous ring buffer of trace entries; a push into a full buffer is accepted only alongside a pop.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  trace_entry_t               push_data,
  input  logic                       pop,
  output trace_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t    storage [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = storage[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only: pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures one trace entry per retired instruction (PC change) and flags a core whose PC stops moving.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [31:0]               PC,
  input  logic [31:0]               F,
  input  logic [31:0]               Mem,
  input  logic                      ZF,
  input  logic                      OF,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [31:0]               rd_pc,
  output logic [31:0]               rd_f,
  output logic [31:0]               rd_mem,
  output logic                      rd_zf,
  output logic                      rd_of,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DROP_CNT_W-1:0]     dropped,
  output logic                      halted
);

  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(HALT_CYCLES);
  localparam logic [SW-1:0] STALL_LAST = SW'(HALT_CYCLES - 1);

  logic [31:0]   last_pc;
  logic          last_pc_valid;
  logic [SW-1:0] stall_cnt;
  logic          retire;
  logic          stall;
  logic          pop;
  logic          full;
  logic          empty;
  trace_entry_t  push_entry;
  trace_entry_t  head;

  always_comb begin
    retire     = en & (~last_pc_valid | (PC != last_pc));
    stall      = en & last_pc_valid & (PC == last_pc);
    pop        = rd_valid & rd_ready;
    push_entry = '{pc: PC, f: F, mem: Mem, zf: ZF, of: OF};
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_valid <= 1'b0;
      stall_cnt     <= '0;
      halted        <= 1'b0;
      dropped       <= '0;
    end else begin
      if (retire) begin
        last_pc_valid <= 1'b1;
        stall_cnt     <= '0;
      end else if (stall) begin
        if (stall_cnt != STALL_MAX)  stall_cnt <= stall_cnt + SW'(1);
        if (stall_cnt == STALL_LAST) halted    <= 1'b1;
      end
      // A full buffer only loses the entry when no pop frees a slot on this edge.
      if (retire & full & ~pop & (dropped != '1))
        dropped <= dropped + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (retire) last_pc <= PC;
  end

  always_comb begin
    rd_valid = ~empty;
    rd_pc    = rd_valid ? head.pc  : '0;
    rd_f     = rd_valid ? head.f   : '0;
    rd_mem   = rd_valid ? head.mem : '0;
    rd_zf    = rd_valid & head.zf;
    rd_of    = rd_valid & head.of;
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Table vectors, directed corner sequences and a randomized queue-model run for cpu_trace_buffer.
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int HALT  = 8;

  logic        clk = 1'b0;
  logic        rst, en, ZF, OF, rd_ready;
  logic [31:0] PC, F, Mem;
  logic        rd_valid, rd_zf, rd_of, halted;
  logic [31:0] rd_pc, rd_f, rd_mem;
  logic [4:0]  count;
  logic [15:0] dropped;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(DEPTH), .HALT_CYCLES(HALT)) dut (
    .clk(clk), .rst(rst), .en(en), .PC(PC), .F(F), .Mem(Mem), .ZF(ZF), .OF(OF),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_f(rd_f),
    .rd_mem(rd_mem), .rd_zf(rd_zf), .rd_of(rd_of), .count(count),
    .dropped(dropped), .halted(halted)
  );

  // Behavioural reference: a bounded queue plus a few scalars.
  typedef struct { logic [31:0] pc, f, mem; logic zf, of; } ent_t;
  ent_t        mq[$];
  int          m_drop;
  bit          m_halt, m_have_pc;
  logic [31:0] m_pc;
  int          m_stalls;

  task automatic model_step(input logic r, e, input logic [31:0] p, fv, mv,
                            input logic z, o, rdy);
    bit popped, full_before;
    ent_t n;
    if (r) begin
      mq.delete(); m_drop = 0; m_halt = 0; m_have_pc = 0; m_stalls = 0;
      return;
    end
    full_before = (mq.size() == DEPTH);
    popped = (mq.size() != 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (e) begin
      if (!m_have_pc || p != m_pc) begin
        n.pc = p; n.f = fv; n.mem = mv; n.zf = z; n.of = o;
        if (!full_before || popped) mq.push_back(n);
        else if (m_drop < 65535) m_drop++;
        m_pc = p; m_have_pc = 1; m_stalls = 0;
      end else begin
        m_stalls++;
        if (m_stalls >= HALT) m_halt = 1;
      end
    end
  endtask

  task automatic tick(input logic r, e, input logic [31:0] p, fv, mv,
                      input logic z, o, rdy);
    rst = r; en = e; PC = p; F = fv; Mem = mv; ZF = z; OF = o; rd_ready = rdy;
    @(posedge clk);
    model_step(r, e, p, fv, mv, z, o, rdy);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    ent_t h;
    h = '{default: '0};
    if (mq.size() != 0) h = mq[0];
    chk("m_count",   32'(count),    32'(mq.size()));
    chk("m_valid",   32'(rd_valid), 32'(mq.size() != 0));
    chk("m_pc",      rd_pc,  h.pc);
    chk("m_f",       rd_f,   h.f);
    chk("m_mem",     rd_mem, h.mem);
    chk("m_flags",   {30'd0, rd_zf, rd_of}, {30'd0, h.zf, h.of});
    chk("m_dropped", 32'(dropped),  32'(m_drop));
    chk("m_halted",  32'(halted),   32'(m_halt));
  endtask

  typedef struct {
    logic r, e, rdy;
    logic [31:0] pc, f;
    int   cnt;
    logic vld;
    logic [31:0] epc, ef;
    logic ehalt;
  } vec_t;

  vec_t vt[11];

  initial begin
    rst = 1'b1; en = 1'b0; PC = '0; F = '0; Mem = '0; ZF = 1'b0; OF = 1'b0; rd_ready = 1'b0;
    #1;
    //           r  e  rdy pc      f          cnt vld epc     ef        halt
    vt[0]  = '{1, 0, 0, 32'h0,  32'h0,     0, 0, 32'h0,  32'h0,    0};
    vt[1]  = '{0, 1, 0, 32'h0,  32'h100,   1, 1, 32'h0,  32'h100,  0};
    vt[2]  = '{0, 1, 0, 32'h4,  32'h104,   2, 1, 32'h0,  32'h100,  0};
    vt[3]  = '{0, 1, 0, 32'h8,  32'h108,   3, 1, 32'h0,  32'h100,  0};
    vt[4]  = '{0, 0, 1, 32'h8,  32'h0,     2, 1, 32'h4,  32'h104,  0};
    vt[5]  = '{0, 0, 1, 32'h8,  32'h0,     1, 1, 32'h8,  32'h108,  0};
    vt[6]  = '{0, 0, 1, 32'h8,  32'h0,     0, 0, 32'h0,  32'h0,    0};
    vt[7]  = '{0, 0, 0, 32'h20, 32'h220,   0, 0, 32'h0,  32'h0,    0};
    vt[8]  = '{0, 0, 0, 32'h24, 32'h224,   0, 0, 32'h0,  32'h0,    0};
    vt[9]  = '{0, 1, 0, 32'h24, 32'h324,   1, 1, 32'h24, 32'h324,  0};
    vt[10] = '{0, 1, 0, 32'h24, 32'h424,   1, 1, 32'h24, 32'h324,  0};
    for (int i = 0; i < 11; i++) begin
      tick(vt[i].r, vt[i].e, vt[i].pc, vt[i].f, ~vt[i].pc, vt[i].pc[2], 1'b0, vt[i].rdy);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vt[i].vld));
      chk($sformatf("v%0d_pc", i), rd_pc, vt[i].epc);
      chk($sformatf("v%0d_f", i), rd_f, vt[i].ef);
      chk($sformatf("v%0d_halt", i), 32'(halted), 32'(vt[i].ehalt));
    end
    chk("v_mem_head", rd_mem, ~32'h24);

    // Halt: PC 0x10 held for 10 samples, then moves to 0x14.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 32'h10, 32'(i), 0, 0, 0, 0);
      if (i == 8) chk("halt_before", 32'(halted), 0);
      if (i == 9) chk("halt_at_8th_stall", 32'(halted), 1);
    end
    chk("halt_one_entry", 32'(count), 1);
    tick(0, 1, 32'h14, 0, 0, 0, 0, 0);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_capture_continues", 32'(count), 2);

    // Overflow: 20 distinct PCs into a 16-deep buffer, then full push+pop.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 32'h1000 + 32'(i*4), 32'(i), 0, 0, 0, 0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_dropped", 32'(dropped), 4);
    chk("ovf_head", rd_pc, 32'h1000);
    tick(0, 1, 32'h2000, 32'hAA, 0, 1, 1, 1);
    chk("fullpp_count", 32'(count), 16);
    chk("fullpp_dropped", 32'(dropped), 4);
    chk("fullpp_head", rd_pc, 32'h1004);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d_pc", i), rd_pc, 32'h1000 + 32'(i*4));
      tick(0, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("drain_newest_pc", rd_pc, 32'h2000);
    chk("drain_newest_flags", {30'd0, rd_zf, rd_of}, 32'd3);

    // Reset mid-operation with entries stored and halted set.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 32'h40 + 32'(i*4), 0, 0, 0, 0, 0);
    for (int i = 0; i < HALT; i++) tick(0, 1, 32'h50, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_halt", 32'(halted), 1);
    tick(1, 1, 32'h50, 0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_pc", rd_pc, 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_halt", 32'(halted), 0);
    tick(0, 1, 32'h50, 32'h77, 0, 0, 0, 0);
    chk("post_rst_capture", 32'(count), 1);
    chk("post_rst_pc", rd_pc, 32'h50);

    // Randomized run against the queue model.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    begin
      logic [31:0] p;
      p = 32'h0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(3) == 0) p = {$urandom_range(7), 2'b00};
        tick($urandom_range(299) == 0, $urandom_range(3) != 0, p, $urandom, $urandom,
             1'($urandom), 1'($urandom), $urandom_range(2) == 0);
        chk_model();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Retirement-trace capture stage sitting directly downstream of the CPU core. Each cycle it samples the core's observation outputs (PC, F, Mem, ZF, OF) and detects instruction retirement as a change of PC. It pushes one trace entry per retired instruction into an internal ring buffer, which the bench or debug logic drains through a valid/ready read port. It also flags a halted core: PC stuck for a programmable number of cycles.

## Interface
- DEPTH, 16, trace entries stored; power of two, ≥2
- HALT_CYCLES, 8, consecutive unchanged-PC samples that declare a halt; ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  capture enable; when 0, nothing is sampled, compared or pushed
- PC  in  32  core program counter
- F  in  32  core ALU result
- Mem  in  32  core memory read data
- ZF  in  1  core zero flag
- OF  in  1  core overflow flag
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_pc, rd_f, rd_mem  out  32 each  head entry fields
- rd_zf, rd_of  out  1 each  head entry flags
- count  out  $clog2(DEPTH)+1  entries currently stored
- dropped  out  16  entries lost to full buffer, saturates at 16'hFFFF
- halted  out  1  sticky halt indication

## Operation
- Tracking registers: last_pc (32), last_pc_valid (1), stall_cnt (saturating at HALT_CYCLES).
- Sample event: rising edge with en=1.
- Retire condition: a sample with last_pc_valid=0, or with PC != last_pc. On retire:
  - push {PC, F, Mem, ZF, OF};
  - last_pc <= PC, last_pc_valid <= 1, stall_cnt <= 0.
- Stall condition: a sample with last_pc_valid=1 and PC == last_pc. On stall:
  - no push;
  - stall_cnt <= stall_cnt+1 (saturating);
  - halted <= 1 on the sample where stall_cnt+1 reaches HALT_CYCLES.
- halted is sticky until rst; a later PC change does not clear it; capture continues after halt.
- Push into a full buffer with no simultaneous pop:
  - entry discarded, buffer contents unchanged;
  - dropped increments (saturating).
- Pop: rd_valid & rd_ready at the edge. Head advances, count decrements.
- Simultaneous push and pop:
  - accepted even when full; count unchanged, dropped unchanged;
  - when empty, only the push takes effect (no bypass; rd_valid was 0).
- rd_pc/rd_f/rd_mem/rd_zf/rd_of show the head entry while rd_valid=1 and are driven 0 while rd_valid=0.
- rd_valid = (count != 0).
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (rst=1 at an edge) sets: count=0, rd_valid=0, all rd_* = 0, dropped=0, halted=0, last_pc_valid=0, stall_cnt=0, pointers=0. Storage contents need no reset.
- rst has priority over en, push and pop in the same cycle. Asserting it mid-operation discards all stored entries.
- Push latency: entry sampled at edge N → rd_valid=1 and rd_* valid after edge N, i.e. during cycle N+1.
- Pop: head held stable while rd_valid=1 and rd_ready=0. Next entry (or rd_valid=0) appears the cycle after the accepting edge.
- count, dropped and halted update on the same edge as the event causing them.
- halted rises after the edge of the HALT_CYCLES-th consecutive stall sample.

## Structure
- Package cpu_trace_pkg holds:
  - trace_entry_t (pc, f, mem, zf, of; 98 bits);
  - TRACE_ENTRY_W = 98;
  - DROP_CNT_W = 16.
- Sub-module trace_fifo: synchronous DEPTH×trace_entry_t ring buffer with push/pop/full/empty/count. It implements the full-with-pop acceptance rule.
- The top level contains the retire/stall detector, halt logic and the drop counter.

## Test plan
- Reset, en=1, PC sequence 0,4,8 on three edges, rd_ready=0 → count=3. Entries read back in order with PC 0,4,8 and matching F/Mem/ZF/OF. rd_valid first seen 1 in the cycle after the first sample.
- PC held at 0x10 for 10 samples with HALT_CYCLES=8 → exactly one entry. halted=1 after the 8th stall sample, and it stays 1 after PC moves to 0x14.
- DEPTH=16, rd_ready=0, 20 distinct PCs → count=16, dropped=4. Entries hold the first 16 PCs.
- Buffer full, rd_ready=1 and new PC in the same cycle → count stays 16, dropped unchanged. Head advances and the newest entry is stored.
- en=0 while PC changes 0x20→0x24, then en=1 with PC=0x24 → exactly one entry (PC 0x24), no stall counted.
- rst asserted with count=5 and halted=1 → next cycle count=0, rd_valid=0, rd_pc=0, dropped=0, halted=0. The first enabled sample is captured regardless of its PC value.
